// File: rtl/pid_motor_io_if.sv
// PID-side and CPU-side buses of pid_motor_io: the PID's address/ce/m_k_out/error
// exchange plus the setpoint write / position read port.
interface pid_motor_io_if #(
  parameter int aw = 1,
  parameter int ew = 24,
  parameter int ow = 12
);
  logic [aw-1:0]        a;
  logic                 ce;
  logic signed [ow-1:0] m_k_out;
  logic signed [ew-1:0] error;
  logic                 sp_we;
  logic [aw-1:0]        sp_addr;
  logic signed [ew-1:0] sp_data;
  logic signed [ew-1:0] pos_q;

  modport master (
    output a, ce, m_k_out, sp_we, sp_addr, sp_data,
    input  error, pos_q
  );

  modport slave (
    input  a, ce, m_k_out, sp_we, sp_addr, sp_data,
    output error, pos_q
  );
endinterface

// File: rtl/pid_motor_io.sv
// Plant-side I/O for the PID: quadrature position counters, setpoints, saturated
// error feed and sign/magnitude PWM per channel. Optional macro: ENCODER_FILTER_EN.
module pid_motor_io #(
  parameter  int aw = 1,
  parameter  int ew = 24,
  parameter  int ow = 12,
  localparam int an = 1 << aw,
  localparam int pw = ow - 1
) (
  input  logic          clk_pid,
  input  logic          reset_n,
  pid_motor_io_if.slave bus,
  input  logic [an-1:0] enc_a,
  input  logic [an-1:0] enc_b,
  output logic [an-1:0] quad_err,
  output logic [an-1:0] pwm_out,
  output logic [an-1:0] dir_out
);
  typedef logic signed [ew-1:0] word_t;
  typedef logic [pw-1:0]        duty_t;

  localparam word_t WORD_MAX = {1'b0, {(ew-1){1'b1}}};
  localparam word_t WORD_MIN = {1'b1, {(ew-1){1'b0}}};

  // Gray AB to a 2-bit phase index so a step is just a modulo-4 difference.
  function automatic logic [1:0] ab_to_bin(input logic pa, input logic pb);
    return {pa, pa ^ pb};
  endfunction

  logic [an-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic [an-1:0] b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic [an-1:0] dec_a, dec_b;
  logic [an-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d;

  word_t         pos_q [an];
  word_t         pos_d [an];
  word_t         sp_q  [an];
  word_t         sp_d  [an];
  logic [an-1:0] quad_err_q, quad_err_d;
  word_t         pos_rd_q, pos_rd_d;
  word_t         error_q, error_d;
  logic signed [ew:0] diff;

  logic          ce_dly_q, ce_dly_d;
  logic          capture;
  logic [ow-1:0] neg_mk;
  duty_t         mag;
  duty_t         pend_duty_q [an];
  duty_t         pend_duty_d [an];
  duty_t         duty_q [an];
  duty_t         duty_d [an];
  logic [an-1:0] pend_dir_q, pend_dir_d, dir_q, dir_d;
  duty_t         cnt_q, cnt_d;
  logic [an-1:0] pwm_q, pwm_d, dir_out_q, dir_out_d;

  // NOTE: every _d is given its default before any branch, so no path can infer a latch.
  always_comb begin
    a_s1_d     = enc_a;
    a_s2_d     = a_s1_q;
    b_s1_d     = enc_b;
    b_s2_d     = b_s1_q;
    prev_a_d   = dec_a;
    prev_b_d   = dec_b;
    pos_d      = pos_q;
    sp_d       = sp_q;
    quad_err_d = quad_err_q;

    if (bus.sp_we) begin
      sp_d[bus.sp_addr]       = bus.sp_data;
      quad_err_d[bus.sp_addr] = 1'b0;
    end
    // Decoding follows the write so an illegal jump in the same cycle wins over the clear.
    for (int i = 0; i < an; i++) begin
      case (2'(ab_to_bin(dec_a[i], dec_b[i]) - ab_to_bin(prev_a_q[i], prev_b_q[i])))
        2'd1:    pos_d[i] = pos_q[i] + word_t'(1);
        2'd3:    pos_d[i] = pos_q[i] - word_t'(1);
        2'd2:    quad_err_d[i] = 1'b1;
        default: ;
      endcase
    end
    pos_rd_d = pos_q[bus.sp_addr];

    diff = {sp_q[bus.a][ew-1], sp_q[bus.a]} - {pos_q[bus.a][ew-1], pos_q[bus.a]};
    if (diff[ew] != diff[ew-1]) error_d = diff[ew] ? WORD_MIN : WORD_MAX;
    else                        error_d = diff[ew-1:0];
  end

  always_comb begin
    ce_dly_d = bus.ce;
    capture  = bus.ce & ~ce_dly_q;
    neg_mk   = -bus.m_k_out;
    // Only the most negative code is still negative after negation; it clamps to full scale.
    if (!bus.m_k_out[ow-1]) mag = bus.m_k_out[pw-1:0];
    else if (neg_mk[ow-1])  mag = '1;
    else                    mag = neg_mk[pw-1:0];

    pend_duty_d = pend_duty_q;
    pend_dir_d  = pend_dir_q;
    if (capture) begin
      pend_duty_d[bus.a] = mag;
      pend_dir_d[bus.a]  = bus.m_k_out[ow-1];
    end

    cnt_d  = cnt_q + duty_t'(1);
    duty_d = duty_q;
    dir_d  = dir_q;
    // New duty only takes effect at the period boundary, so no runt pulses.
    if (cnt_q == '1) begin
      duty_d = pend_duty_q;
      dir_d  = pend_dir_q;
    end
    for (int i = 0; i < an; i++) pwm_d[i] = (cnt_q < duty_q[i]);
    dir_out_d = dir_q;
  end

  // NOTE: state updates use non-blocking assignments; blocking here would race other flops.
  always_ff @(posedge clk_pid or negedge reset_n) begin
    if (!reset_n) begin
      a_s1_q     <= '0;
      a_s2_q     <= '0;
      b_s1_q     <= '0;
      b_s2_q     <= '0;
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      quad_err_q <= '0;
      pos_rd_q   <= '0;
      error_q    <= '0;
      ce_dly_q   <= 1'b0;
      pend_dir_q <= '0;
      dir_q      <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      dir_out_q  <= '0;
      // NOTE: these per-channel arrays need a known value after reset, so they are flops, not RAM.
      for (int i = 0; i < an; i++) begin
        pos_q[i]       <= '0;
        sp_q[i]        <= '0;
        pend_duty_q[i] <= '0;
        duty_q[i]      <= '0;
      end
    end else begin
      a_s1_q      <= a_s1_d;
      a_s2_q      <= a_s2_d;
      b_s1_q      <= b_s1_d;
      b_s2_q      <= b_s2_d;
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      quad_err_q  <= quad_err_d;
      pos_rd_q    <= pos_rd_d;
      error_q     <= error_d;
      ce_dly_q    <= ce_dly_d;
      pend_dir_q  <= pend_dir_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      dir_out_q   <= dir_out_d;
      pos_q       <= pos_d;
      sp_q        <= sp_d;
      pend_duty_q <= pend_duty_d;
      duty_q      <= duty_d;
    end
  end

  assign quad_err  = quad_err_q;
  assign pwm_out   = pwm_q;
  assign dir_out   = dir_out_q;
  assign bus.error = error_q;
  assign bus.pos_q = pos_rd_q;

`ifdef ENCODER_FILTER_EN
  // A phase follows the synchronised input only after three equal samples in a row.
  logic [an-1:0] a_h1_q, a_h1_d, a_h2_q, a_h2_d, a_f_q, a_f_d, a_eq;
  logic [an-1:0] b_h1_q, b_h1_d, b_h2_q, b_h2_d, b_f_q, b_f_d, b_eq;

  always_comb begin
    a_eq   = ~(a_s2_q ^ a_h1_q) & ~(a_h1_q ^ a_h2_q);
    b_eq   = ~(b_s2_q ^ b_h1_q) & ~(b_h1_q ^ b_h2_q);
    a_h1_d = a_s2_q;
    a_h2_d = a_h1_q;
    b_h1_d = b_s2_q;
    b_h2_d = b_h1_q;
    a_f_d  = (a_f_q & ~a_eq) | (a_s2_q & a_eq);
    b_f_d  = (b_f_q & ~b_eq) | (b_s2_q & b_eq);
  end

  always_ff @(posedge clk_pid or negedge reset_n) begin
    if (!reset_n) begin
      a_h1_q <= '0;
      a_h2_q <= '0;
      a_f_q  <= '0;
      b_h1_q <= '0;
      b_h2_q <= '0;
      b_f_q  <= '0;
    end else begin
      a_h1_q <= a_h1_d;
      a_h2_q <= a_h2_d;
      a_f_q  <= a_f_d;
      b_h1_q <= b_h1_d;
      b_h2_q <= b_h2_d;
      b_f_q  <= b_f_d;
    end
  end

  assign dec_a = a_f_q;
  assign dec_b = b_f_q;
`else
  assign dec_a = a_s2_q;
  assign dec_b = b_s2_q;
`endif
endmodule
